ps2_cursor_ctrl: RTL and testbench
==================================

# ps2_cursor_ctrl

Keyboard front end for the minesweeper game. It receives PS/2 scan-code set 2 frames from the keyboard and tracks the cursor on the 15×15 board. It issues one-cycle reveal, flag and restart commands to `game_play`, and exposes the cursor position to `minesweeper_graph`. It runs entirely on the pixel clock.

## Interface
Parameters:
- `GRID_N`, 15: board dimension; cursor coordinates range 0..GRID_N-1.
- `START_XY`, 7: cursor X and Y after reset and after restart.
- `TIMEOUT_CYC`, 50000: clk_pix cycles without a falling ps2_clk edge, mid-frame, before the frame is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk_pix`  in  1  pixel clock, 25 MHz; the only clock.
- `sim_rst`  in  1  synchronous active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `current_x`  out  4  cursor column.
- `current_y`  out  4  cursor row.
- `clicked_cell_x`  out  4  column latched at the last reveal/flag command.
- `clicked_cell_y`  out  4  row latched at the last reveal/flag command.
- `cell_click`  out  1  reveal command, one-cycle pulse.
- `right_click`  out  1  flag command, one-cycle pulse.
- `restart_game`  out  1  restart command, one-cycle pulse.
- `frame_err`  out  1  one-cycle pulse on a bad frame or a timeout.

## Operation
- **Input synchronisation:** ps2_clk and ps2_data each pass through a 2-FF synchroniser. A falling edge is detected from the synchronised ps2_clk (previous=1, current=0). Data is sampled on that edge.
- **Receiver FSM:**
  - States: IDLE, SHIFT, CHECK.
  - IDLE → SHIFT: on a falling edge with data=0 (start bit). If data=1, stay in IDLE and pulse nothing.
  - SHIFT: collects 8 data bits LSB-first, then the parity bit, then the stop bit, using a 4-bit bit counter.
  - SHIFT → CHECK: after the stop-bit edge.
  - CHECK (one cycle):
    - Frame is valid if parity is odd over data+parity and stop=1.
    - Valid frame: hand the byte to the decoder.
    - Invalid frame: pulse frame_err and discard the byte.
    - Always return to IDLE.
  - Timeout: a 16-bit counter clears on every falling edge and increments while in SHIFT. Reaching TIMEOUT_CYC forces IDLE and pulses frame_err.
- **Decoder flags:**
  - `ext`: set by byte E0.
  - `brk`: set by byte F0.
  - Both flags clear after the next non-prefix byte is consumed.
  - A byte consumed with brk=1 is a release. It clears the matching held flag and generates no command.
- **Key map (make codes):**
  - Arrow up, E0 75: y−1.
  - Arrow down, E0 72: y+1.
  - Arrow left, E0 6B: x−1.
  - Arrow right, E0 74: x+1.
  - 5A (Enter): reveal.
  - 29 (Space): flag.
  - 2D (R): restart.
  - All other codes are ignored.
  - Non-extended 75/72/6B/74 (keypad keys) are ignored.
- **Cursor movement:** saturates at 0 and GRID_N-1; there is no wrap-around. Typematic repeats of arrow makes each move the cursor once.
- **Command keys:** Enter, Space and R are edge-triggered.
  - Each has a held flag, set on its make.
  - A make that arrives while the key's held flag is set produces no command.
  - The key's release clears its held flag.
- **Reveal/flag:** clicked_cell_x/y load current_x/y in the same cycle as the cell_click or right_click pulse.
- **Restart:** pulses restart_game and loads the cursor with START_XY. It also clears ext, brk and all held flags except R's.
- **Reset values:**
  - All pulse outputs 0.
  - current_x/y = START_XY.
  - clicked_cell_x/y = 0.
  - FSM in IDLE; all flags and counters 0.
- **Mid-frame reset:** sim_rst aborts the frame immediately with no frame_err pulse.

## Timing
- ps2_clk edge to synchroniser output: 2 cycles. Edge detect adds 1 more cycle.
- CHECK is the cycle after the stop-bit edge is detected.
- Command pulses and cursor updates are registered and appear the cycle after CHECK, lasting exactly 1 cycle.
- frame_err is asserted in the CHECK cycle, or in the cycle after the timeout counter reaches TIMEOUT_CYC.
- Only one byte is decoded per frame, so at most one command fires per byte. There are never simultaneous pulses.
- Minimum PS/2 input phase: 4 clk_pix cycles high and 4 low. Shorter phases are unsupported.

## Test plan
- **Reset:** reset, then idle 100 cycles → current=(7,7), clicked=(0,0), no pulses.
- **Arrows:**
  - Send E0 74 three times → current_x=10.
  - Send E0 75 ten times → current_y=0 (saturated).
  - Send E0 F0 74 → no change.
- **Reveal and flag:**
  - Move the cursor to (3,12), then send 5A → cell_click is 1 for exactly 1 cycle, clicked=(3,12).
  - Send 5A again with no release → no pulse.
  - Send F0 5A then 29 → right_click pulses, clicked=(3,12).
- **Restart:** from cursor (14,14), send 2D → restart_game pulses once and current=(7,7).
- **Bad frames:**
  - Bad parity on 74 → frame_err pulse, no move.
  - Stop bit 0 → frame_err pulse.
  - Stall ps2_clk after 5 bits for more than 50000 cycles → frame_err pulse, FSM in IDLE; a following good E0 6B moves the cursor left by 1.
- **Reset mid-frame:** assert sim_rst after 6 bits → state as after reset; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_cursor_ctrl.sv
// PS/2 set-2 keyboard receiver and minesweeper cursor/command decoder.
// Everything runs on clk_pix; ps2_clk/ps2_data are synchronised before use.
module ps2_cursor_ctrl #(
  parameter int GRID_N      = 15,
  parameter int START_XY    = 7,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_pix,
  input  logic       sim_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] current_x,
  output logic [3:0] current_y,
  output logic [3:0] clicked_cell_x,
  output logic [3:0] clicked_cell_y,
  output logic       cell_click,
  output logic       right_click,
  output logic       restart_game,
  output logic       frame_err
);

  localparam logic [3:0]  MAX_XY = 4'(GRID_N - 1);
  localparam logic [3:0]  ST_XY  = 4'(START_XY);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_clk_s1, r_clk_s2, r_clk_prev;
  logic        r_dat_s1, r_dat_s2;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_parity, r_stop;
  logic [15:0] r_to_cnt;
  logic        w_fall, w_valid, w_err, w_byte_ok;

  logic [3:0]  r_cur_x, r_cur_y, r_clk_x, r_clk_y;
  logic        r_ext, r_brk, r_held_enter, r_held_space, r_held_r;
  logic        r_click, r_right, r_restart;

  assign w_fall  = r_clk_prev & ~r_clk_s2;
  assign w_valid = (^{r_shift, r_parity}) & r_stop;

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (sim_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      IDLE:  if (w_fall && !r_dat_s2) w_state_nxt = SHIFT;
      SHIFT: begin
        if (r_to_cnt == TO_LIM) begin
          w_state_nxt = IDLE;
          w_err       = 1'b1;
        end else if (w_fall && r_bitcnt == 4'd9) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_err       = ~w_valid;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated so a CHECK cycle coinciding with reset cannot report an error.
  assign frame_err = w_err & ~sim_rst;
  assign w_byte_ok = (r_state == CHECK) && w_valid;

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_stop   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_fall || r_state != SHIFT) r_to_cnt <= '0;
      else                            r_to_cnt <= r_to_cnt + 16'd1;

      if (r_state == IDLE) begin
        r_bitcnt <= '0;
      end else if (r_state == SHIFT && w_fall) begin
        if (r_bitcnt < 4'd8)       r_shift  <= {r_dat_s2, r_shift[7:1]};
        else if (r_bitcnt == 4'd8) r_parity <= r_dat_s2;
        else                       r_stop   <= r_dat_s2;
        r_bitcnt <= r_bitcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (sim_rst) begin
      r_cur_x      <= ST_XY;
      r_cur_y      <= ST_XY;
      r_clk_x      <= '0;
      r_clk_y      <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_held_enter <= 1'b0;
      r_held_space <= 1'b0;
      r_held_r     <= 1'b0;
      r_click      <= 1'b0;
      r_right      <= 1'b0;
      r_restart    <= 1'b0;
    end else begin
      r_click   <= 1'b0;
      r_right   <= 1'b0;
      r_restart <= 1'b0;
      if (w_byte_ok) begin
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_brk) begin
            if (!r_ext && r_shift == 8'h5A) r_held_enter <= 1'b0;
            if (!r_ext && r_shift == 8'h29) r_held_space <= 1'b0;
            if (!r_ext && r_shift == 8'h2D) r_held_r     <= 1'b0;
          end else if (r_ext) begin
            case (r_shift)
              8'h75: if (r_cur_y != 4'd0)   r_cur_y <= r_cur_y - 4'd1;
              8'h72: if (r_cur_y < MAX_XY)  r_cur_y <= r_cur_y + 4'd1;
              8'h6B: if (r_cur_x != 4'd0)   r_cur_x <= r_cur_x - 4'd1;
              8'h74: if (r_cur_x < MAX_XY)  r_cur_x <= r_cur_x + 4'd1;
              default: ;
            endcase
          end else begin
            case (r_shift)
              8'h5A: begin
                r_held_enter <= 1'b1;
                if (!r_held_enter) begin
                  r_click <= 1'b1;
                  r_clk_x <= r_cur_x;
                  r_clk_y <= r_cur_y;
                end
              end
              8'h29: begin
                r_held_space <= 1'b1;
                if (!r_held_space) begin
                  r_right <= 1'b1;
                  r_clk_x <= r_cur_x;
                  r_clk_y <= r_cur_y;
                end
              end
              8'h2D: begin
                r_held_r <= 1'b1;
                if (!r_held_r) begin
                  r_restart    <= 1'b1;
                  r_cur_x      <= ST_XY;
                  r_cur_y      <= ST_XY;
                  r_held_enter <= 1'b0;
                  r_held_space <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign current_x      = r_cur_x;
  assign current_y      = r_cur_y;
  assign clicked_cell_x = r_clk_x;
  assign clicked_cell_y = r_clk_y;
  assign cell_click     = r_click;
  assign right_click    = r_right;
  assign restart_game   = r_restart;

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Directed bench for ps2_cursor_ctrl: PS/2 frames in, cursor/command pulses checked.
module tb_ps2_cursor_ctrl;

  localparam int HALF = 6;

  logic       clk_pix = 1'b0;
  logic       sim_rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] current_x, current_y, clicked_cell_x, clicked_cell_y;
  logic       cell_click, right_click, restart_game, frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  int c_click = 0, c_right = 0, c_restart = 0, c_err = 0, c_multi = 0;
  logic [3:0] lx = '0, ly = '0;

  ps2_cursor_ctrl #(.GRID_N(15), .START_XY(7), .TIMEOUT_CYC(50000)) dut (
    .clk_pix(clk_pix), .sim_rst(sim_rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .current_x(current_x), .current_y(current_y),
    .clicked_cell_x(clicked_cell_x), .clicked_cell_y(clicked_cell_y),
    .cell_click(cell_click), .right_click(right_click),
    .restart_game(restart_game), .frame_err(frame_err)
  );

  always #20 clk_pix = ~clk_pix;

  always @(negedge clk_pix) begin
    if (cell_click)   begin c_click++; lx = clicked_cell_x; ly = clicked_cell_y; end
    if (right_click)  begin c_right++; lx = clicked_cell_x; ly = clicked_cell_y; end
    if (restart_game) c_restart++;
    if (frame_err)    c_err++;
    if (32'(cell_click) + 32'(right_click) + 32'(restart_game) + 32'(frame_err) > 1) c_multi++;
  end

  task automatic ps2_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk_pix);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_pix);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_pix);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bits({~bad_stop, p, b, 1'b0}, 11);
    repeat (2 * HALF) @(negedge clk_pix);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b0, 1'b0);
  endtask

  task automatic send_arrow(input logic [7:0] b, input int unsigned times);
    for (int unsigned i = 0; i < times; i++) begin
      send_byte(8'hE0);
      send_byte(b);
    end
  endtask

  task automatic do_reset();
    sim_rst = 1'b1;
    repeat (4) @(negedge clk_pix);
    sim_rst = 1'b0;
  endtask

  task automatic test_reset();
    int e0, k0;
    do_reset();
    e0 = c_err; k0 = c_click + c_right + c_restart;
    repeat (100) @(negedge clk_pix);
    n_tests++;
    if ({current_x, current_y} !== {4'd7, 4'd7}) begin
      n_fail++; $display("FAIL reset_cursor got (%0d,%0d) want (7,7)", current_x, current_y);
    end
    n_tests++;
    if ({clicked_cell_x, clicked_cell_y} !== 8'h00) begin
      n_fail++; $display("FAIL reset_clicked got (%0d,%0d) want (0,0)", clicked_cell_x, clicked_cell_y);
    end
    n_tests++;
    if ((c_click + c_right + c_restart - k0) !== 0 || (c_err - e0) !== 0) begin
      n_fail++; $display("FAIL reset_pulses got %0d cmd %0d err want 0", c_click + c_right + c_restart - k0, c_err - e0);
    end
  endtask

  task automatic test_arrows();
    int k0;
    k0 = c_click + c_right + c_restart + c_err;
    send_arrow(8'h74, 3);
    n_tests++;
    if (current_x !== 4'd10) begin n_fail++; $display("FAIL arrow_right got %0d want 10", current_x); end
    send_arrow(8'h75, 10);
    n_tests++;
    if (current_y !== 4'd0) begin n_fail++; $display("FAIL arrow_up_sat got %0d want 0", current_y); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    n_tests++;
    if ({current_x, current_y} !== {4'd10, 4'd0}) begin
      n_fail++; $display("FAIL arrow_release got (%0d,%0d) want (10,0)", current_x, current_y);
    end
    send_byte(8'h74);
    n_tests++;
    if (current_x !== 4'd10) begin n_fail++; $display("FAIL keypad_ignored got %0d want 10", current_x); end
    send_arrow(8'h74, 6);
    n_tests++;
    if (current_x !== 4'd14) begin n_fail++; $display("FAIL arrow_right_sat got %0d want 14", current_x); end
    n_tests++;
    if ((c_click + c_right + c_restart + c_err - k0) !== 0) begin
      n_fail++; $display("FAIL arrow_no_pulse got %0d want 0", c_click + c_right + c_restart + c_err - k0);
    end
  endtask

  task automatic test_reveal_flag();
    int c0, r0;
    send_arrow(8'h6B, 11);
    send_arrow(8'h72, 12);
    n_tests++;
    if ({current_x, current_y} !== {4'd3, 4'd12}) begin
      n_fail++; $display("FAIL move_to_3_12 got (%0d,%0d) want (3,12)", current_x, current_y);
    end
    c0 = c_click;
    send_byte(8'h5A);
    n_tests++;
    if ((c_click - c0) !== 1) begin n_fail++; $display("FAIL reveal_pulse got %0d cycles want 1", c_click - c0); end
    n_tests++;
    if ({lx, ly} !== {4'd3, 4'd12} || {clicked_cell_x, clicked_cell_y} !== {4'd3, 4'd12}) begin
      n_fail++; $display("FAIL reveal_clicked got (%0d,%0d) want (3,12)", lx, ly);
    end
    c0 = c_click;
    send_byte(8'h5A);
    n_tests++;
    if ((c_click - c0) !== 0) begin n_fail++; $display("FAIL reveal_held got %0d want 0", c_click - c0); end
    c0 = c_click; r0 = c_right;
    lx = '0; ly = '0;
    send_byte(8'hF0); send_byte(8'h5A); send_byte(8'h29);
    n_tests++;
    if ((c_right - r0) !== 1 || (c_click - c0) !== 0) begin
      n_fail++; $display("FAIL flag_pulse got right %0d click %0d want 1 0", c_right - r0, c_click - c0);
    end
    n_tests++;
    if ({lx, ly} !== {4'd3, 4'd12}) begin n_fail++; $display("FAIL flag_clicked got (%0d,%0d) want (3,12)", lx, ly); end
  endtask

  task automatic test_restart();
    int r0;
    send_arrow(8'h74, 11);
    send_arrow(8'h72, 2);
    n_tests++;
    if ({current_x, current_y} !== {4'd14, 4'd14}) begin
      n_fail++; $display("FAIL move_to_14_14 got (%0d,%0d) want (14,14)", current_x, current_y);
    end
    r0 = c_restart;
    send_byte(8'h2D);
    n_tests++;
    if ((c_restart - r0) !== 1) begin n_fail++; $display("FAIL restart_pulse got %0d want 1", c_restart - r0); end
    n_tests++;
    if ({current_x, current_y} !== {4'd7, 4'd7}) begin
      n_fail++; $display("FAIL restart_cursor got (%0d,%0d) want (7,7)", current_x, current_y);
    end
    send_arrow(8'h75, 1);
    r0 = c_restart;
    send_byte(8'h2D);
    n_tests++;
    if ((c_restart - r0) !== 0 || current_y !== 4'd6) begin
      n_fail++; $display("FAIL restart_held got %0d y=%0d want 0 y=6", c_restart - r0, current_y);
    end
    send_byte(8'hF0); send_byte(8'h2D);
    send_arrow(8'h72, 1);
  endtask

  task automatic test_bad_frames();
    int e0;
    e0 = c_err;
    send_byte(8'hE0);
    send_raw(8'h74, 1'b1, 1'b0);
    n_tests++;
    if ((c_err - e0) !== 1 || current_x !== 4'd7) begin
      n_fail++; $display("FAIL bad_parity got err %0d x=%0d want 1 x=7", c_err - e0, current_x);
    end
    e0 = c_err;
    send_raw(8'h74, 1'b0, 1'b1);
    n_tests++;
    if ((c_err - e0) !== 1 || current_x !== 4'd7) begin
      n_fail++; $display("FAIL bad_stop got err %0d x=%0d want 1 x=7", c_err - e0, current_x);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = c_err;
    ps2_bits({1'b1, 1'b0, 8'h74, 1'b0}, 5);
    repeat (50100) @(negedge clk_pix);
    n_tests++;
    if ((c_err - e0) !== 1) begin n_fail++; $display("FAIL timeout_err got %0d want 1", c_err - e0); end
    n_tests++;
    if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL timeout_idle got %0d want 0", dut.r_state); end
    send_arrow(8'h6B, 1);
    n_tests++;
    if ({current_x, current_y} !== {4'd6, 4'd7}) begin
      n_fail++; $display("FAIL timeout_recover got (%0d,%0d) want (6,7)", current_x, current_y);
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    e0 = c_err;
    ps2_bits({1'b1, 1'b0, 8'h72, 1'b0}, 6);
    do_reset();
    repeat (5) @(negedge clk_pix);
    n_tests++;
    if ({current_x, current_y, clicked_cell_x, clicked_cell_y} !== {4'd7, 4'd7, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL midreset_state got (%0d,%0d) (%0d,%0d) want (7,7) (0,0)",
                         current_x, current_y, clicked_cell_x, clicked_cell_y);
    end
    n_tests++;
    if ((c_err - e0) !== 0 || dut.r_state !== 2'd0) begin
      n_fail++; $display("FAIL midreset_err got err %0d state %0d want 0 0", c_err - e0, dut.r_state);
    end
    send_arrow(8'h72, 1);
    n_tests++;
    if ({current_x, current_y} !== {4'd7, 4'd8}) begin
      n_fail++; $display("FAIL midreset_next got (%0d,%0d) want (7,8)", current_x, current_y);
    end
  endtask

  task automatic test_no_overlap();
    n_tests++;
    if (c_multi !== 0) begin n_fail++; $display("FAIL pulse_overlap got %0d want 0", c_multi); end
  endtask

  initial begin
    test_reset();
    test_arrows();
    test_reveal_flag();
    test_restart();
    test_bad_frames();
    test_timeout();
    test_reset_midframe();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
